// File: rtl/fir_frame_collector.sv
// Collects consecutive FIR output samples into N-sample frames for the FFT.
// Two ping-pong banks let one bank fill while the FFT holds the other.
// Samples that arrive while the target bank is still full are dropped and
// flagged with a sticky overflow bit. Frames are never split or reordered.
module fir_frame_collector #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fir_valid,
  input  logic [W-1:0]   fir_d,
  input  logic           fft_ready,
  output logic           frame_valid,
  output logic [N*W-1:0] frame_data,
  output logic [7:0]     frame_count,
  output logic           overflow
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [W-1:0]     bank_mem [2][N];
  logic [IDX_W-1:0] wr_idx;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic accept;
  logic drop;
  logic frame_done;
  logic consume;

  // Event decode. All terms come from registered state, so a bank freed by a
  // consume at this edge still looks full to the write path (no bypass).
  always_comb begin
    accept     = fir_valid && !full[wr_bank];
    drop       = fir_valid &&  full[wr_bank];
    frame_done = accept && (wr_idx == LAST_IDX);
    consume    = full[rd_bank] && fft_ready;
  end

  // Full-flag update. Completion needs the write bank empty and consume needs
  // the read bank full, so both can fire together only on different banks.
  always_comb begin
    full_nxt = full;
    if (consume) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (frame_done) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  // Sample storage: write the accepted sample into the filling bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_mem[b][k] <= '0;
        end
      end
    end else if (accept) begin
      bank_mem[wr_bank][wr_idx] <= fir_d;
    end
  end

  // Write pointer: advance on accept, hop to the other bank on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      if (frame_done) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  // Bank status, read pointer and handover counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 2'b00;
      rd_bank     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      full <= full_nxt;
      if (consume) begin
        rd_bank     <= ~rd_bank;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Sticky drop indicator; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Output mux: straight from registers, no input-to-output path.
  always_comb begin
    frame_valid = full[rd_bank];
    frame_data  = '0;
    for (int k = 0; k < N; k++) begin
      frame_data[k*W +: W] = bank_mem[rd_bank][k];
    end
  end

endmodule

// File: tb/tb_fir_frame_collector.sv
// Directed bench for fir_frame_collector: table-driven vectors for the plain
// fill cases plus hand-written sequences for stall, race and reset corners.
module tb_fir_frame_collector;

  localparam int N = 16;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           fir_valid;
  logic [W-1:0]   fir_d;
  logic           fft_ready;
  logic           frame_valid;
  logic [N*W-1:0] frame_data;
  logic [7:0]     frame_count;
  logic           overflow;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [7:0]  ecnt;
    logic        eovf;
  } vec_t;

  vec_t tbl [64];
  int   tbl_n;
  logic [W-1:0] exp_frame [N];

  fir_frame_collector #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .fft_ready(fft_ready), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_count(frame_count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name);
    logic [N*W-1:0] e;
    for (int k = 0; k < N; k++) e[k*W +: W] = exp_frame[k];
    checks++;
    if (frame_data !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, frame_data, e);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then sample 1 time unit later.
  task automatic cyc(input logic r, input logic v, input logic [15:0] d, input logic rdy);
    rst = r; fir_valid = v; fir_d = d; fft_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl_n; i++) begin
      cyc(tbl[i].rst, tbl[i].fv, tbl[i].d, tbl[i].rdy);
      chk({name, "_valid"}, 32'(frame_valid), 32'(tbl[i].ev));
      chk({name, "_count"}, 32'(frame_count), 32'(tbl[i].ecnt));
      chk({name, "_ovf"},   32'(overflow),    32'(tbl[i].eovf));
    end
  endtask

  initial begin
    int highs;
    int frm;
    checks = 0; failures = 0;
    rst = 1'b0; fir_valid = 1'b0; fir_d = '0; fft_ready = 1'b0;

    // Test 1: fill, table driven. Entry 0 is reset.
    tbl_n = 17;
    tbl[0] = '{rst:1'b1, fv:1'b1, d:16'h1234, rdy:1'b1, ev:1'b0, ecnt:8'd0, eovf:1'b0};
    for (int k = 0; k < 16; k++)
      tbl[k+1] = '{rst:1'b0, fv:1'b1, d:16'(k), rdy:1'b0,
                   ev:(k == 15), ecnt:8'd0, eovf:1'b0};
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("reset_data", 32'(frame_data == '0), 32'd1);
    run_table("fill");
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(k);
    chk_frame("fill_frame");

    // Test 2: ping-pong with fft_ready held high.
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    highs = 0; frm = 0;
    for (int n = 0; n < 49; n++) begin
      cyc(1'b0, (n < 48), 16'(n), 1'b1);
      if (frame_valid) begin
        highs++;
        for (int k = 0; k < N; k++) exp_frame[k] = 16'(frm*16 + k);
        chk_frame("pingpong_frame");
        frm++;
      end
    end
    chk("pingpong_highs", 32'(highs), 32'd3);
    chk("pingpong_count", 32'(frame_count), 32'd3);
    chk("pingpong_ovf", 32'(overflow), 32'd0);
    chk("pingpong_idle", 32'(frame_valid), 32'd0);

    // Test 3: stall with 40 samples; 32..39 dropped.
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    for (int n = 0; n < 40; n++) cyc(1'b0, 1'b1, 16'(n), 1'b0);
    chk("stall_ovf", 32'(overflow), 32'd1);
    chk("stall_valid", 32'(frame_valid), 32'd1);
    chk("stall_count", 32'(frame_count), 32'd0);
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(k);
    chk_frame("stall_frame0");
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk("stall_valid1", 32'(frame_valid), 32'd1);
    chk("stall_count1", 32'(frame_count), 32'd1);
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(16 + k);
    chk_frame("stall_frame1");
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk("stall_drained", 32'(frame_valid), 32'd0);
    chk("stall_count2", 32'(frame_count), 32'd2);
    for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 16'(100 + n), 1'b0);
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(100 + k);
    chk("stall_valid2", 32'(frame_valid), 32'd1);
    chk_frame("stall_frame2");

    // Test 4: consume/free race. Fill the other bank so both are full.
    for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 16'(200 + n), 1'b0);
    cyc(1'b0, 1'b1, 16'h7FFF, 1'b1);
    chk("race_count", 32'(frame_count), 32'd3);
    chk("race_valid", 32'(frame_valid), 32'd1);
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(200 + k);
    chk_frame("race_frame1");
    cyc(1'b0, 1'b1, 16'h8000, 1'b0);
    for (int n = 1; n < 16; n++) cyc(1'b0, 1'b1, 16'(n), 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk("race_count2", 32'(frame_count), 32'd4);
    chk("race_valid2", 32'(frame_valid), 32'd1);
    exp_frame[0] = 16'h8000;
    for (int k = 1; k < N; k++) exp_frame[k] = 16'(k);
    chk_frame("race_frame2");

    // Test 5: mid-frame reset while a sample is offered.
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    for (int n = 1; n <= 7; n++) cyc(1'b0, 1'b1, 16'(n), 1'b0);
    cyc(1'b1, 1'b1, 16'd99, 1'b0);
    chk("mrst_valid", 32'(frame_valid), 32'd0);
    chk("mrst_count", 32'(frame_count), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_data", 32'(frame_data == '0), 32'd1);
    for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 16'(50 + n), 1'b0);
    chk("mrst_valid1", 32'(frame_valid), 32'd1);
    chk("mrst_count1", 32'(frame_count), 32'd0);
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(50 + k);
    chk_frame("mrst_frame");
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk("mrst_count2", 32'(frame_count), 32'd1);

    // Test 6: gapped input with negative samples, table driven.
    tbl_n = 33;
    tbl[0] = '{rst:1'b1, fv:1'b0, d:16'h0, rdy:1'b0, ev:1'b0, ecnt:8'd0, eovf:1'b0};
    for (int i = 0; i < 16; i++) begin
      tbl[2*i+1] = '{rst:1'b0, fv:1'b0, d:16'hAAAA, rdy:1'b0, ev:1'b0, ecnt:8'd0, eovf:1'b0};
      tbl[2*i+2] = '{rst:1'b0, fv:1'b1, d:16'(-(i+1)), rdy:1'b0,
                     ev:(i == 15), ecnt:8'd0, eovf:1'b0};
    end
    run_table("gaps");
    for (int k = 0; k < N; k++) exp_frame[k] = 16'(-(k+1));
    chk_frame("gaps_frame");
    chk("gaps_word15", 32'(frame_data[15*W +: W]), 32'h0000FFF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
